branch_predict_ctrl: RTL

Branch-prediction and PC-redirect controller for the 5-stage RV32 pipeline. In IF it predicts each fetch with a direct-mapped BTB that holds 2-bit saturating counters. In EX it takes the resolved BEQ/JAL outcome, detects mispredictions and issues the redirect PC and the pipeline flush. It trains the table on every resolved control-flow instruction and counts mispredictions.

---
 rtl/branch_predict_ctrl_pkg.sv | 45 ++++
 rtl/branch_predict_ctrl_if.sv | 47 ++++
 rtl/bp_btb_table.sv | 94 +++++++++
 rtl/branch_predict_ctrl.sv | 86 ++++++++
 4 files changed

// File: rtl/branch_predict_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_ctrl_pkg
//  Description : Shared types for the branch predictor / PC-redirect block:
//                machine word, 2-bit saturating counter, BTB entry layout
//                and the counter training helper.
//  Revision    : 1.0  initial release
// ============================================================================
package branch_predict_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bp_ctr_t;

    // The tag is held in a full word; only the bits above the index are
    // ever non-zero, so synthesis trims the unused upper storage.
    typedef struct packed {
        logic    valid;
        word_t   tag;
        word_t   target;
        bp_ctr_t ctr;
    } bp_entry_t;

    localparam int BP_ENTRIES = 16;
    localparam int BP_CNT_W   = 16;

    // Saturating 2-bit counter step towards the resolved direction.
    function automatic bp_ctr_t ctr_train(bp_ctr_t c, logic taken);
        bp_ctr_t r;
        r = c;
        if (taken) begin
            if (c != ST) r = bp_ctr_t'(c + 2'd1);
        end else begin
            if (c != SNT) r = bp_ctr_t'(c - 2'd1);
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predict_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_ctrl_if
//  Description : Pipeline-side signal bundle of the branch predictor:
//                IF lookup, EX resolve inputs, redirect outputs, statistics.
//  Revision    : 1.0  initial release
// ============================================================================
interface branch_predict_ctrl_if
    import branch_predict_ctrl_pkg::*;
#(
    parameter int CNT_W = BP_CNT_W
);
    logic             stall;
    word_t            if_pc;
    logic             pred_taken;
    word_t            pred_target;
    logic             ex_valid;
    logic             ex_is_branch;
    logic             ex_is_jump;
    logic             ex_zero;
    word_t            ex_pc;
    word_t            ex_target;
    logic             ex_pred_taken;
    word_t            ex_pred_target;
    logic             redirect;
    word_t            redirect_pc;
    logic             flush;
    logic [CNT_W-1:0] mispred_cnt;
    logic [CNT_W-1:0] branch_cnt;

    // Pipeline side: drives fetch PC and EX results, receives predictions.
    modport master (
        output stall, if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_zero,
               ex_pc, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, redirect, redirect_pc, flush,
               mispred_cnt, branch_cnt
    );

    // Predictor side.
    modport slave (
        input  stall, if_pc, ex_valid, ex_is_branch, ex_is_jump, ex_zero,
               ex_pc, ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, redirect, redirect_pc, flush,
               mispred_cnt, branch_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bp_btb_table.sv
`default_nettype none
// ============================================================================
//  Module      : bp_btb_table
//  Description : Direct-mapped BTB with 2-bit counters. One combinational
//                read port for IF prediction, one read-modify-write port
//                for EX training / alias invalidation. Async reset.
//  Revision    : 1.0  initial release
// ============================================================================
module bp_btb_table
    import branch_predict_ctrl_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic  clk,
    input  logic  rst,
    // IF read port
    input  word_t i_rd_pc,
    output logic  o_rd_taken,
    output word_t o_rd_target,
    // EX read-modify-write port
    input  word_t i_ex_pc,
    input  logic  i_wr_en,
    input  logic  i_wr_taken,
    input  logic  i_wr_jump,
    input  word_t i_wr_target,
    input  logic  i_inv_en
);

    bp_entry_t        r_tbl [ENTRIES];

    logic [IDX_W-1:0] w_rd_idx;
    word_t            w_rd_tag;
    bp_entry_t        w_rd_entry;
    logic             w_rd_hit;

    logic [IDX_W-1:0] w_ex_idx;
    word_t            w_ex_tag;
    bp_entry_t        w_ex_entry;
    logic             w_ex_hit;
    logic             w_we;
    bp_entry_t        w_new;

    assign w_rd_idx = i_rd_pc[IDX_W+1:2];
    assign w_rd_tag = i_rd_pc >> (IDX_W + 2);
    assign w_ex_idx = i_ex_pc[IDX_W+1:2];
    assign w_ex_tag = i_ex_pc >> (IDX_W + 2);

    // IF lookup reads registered contents only; an EX write to the same
    // index in the same cycle is not bypassed.
    always_comb begin
        w_rd_entry  = r_tbl[w_rd_idx];
        w_rd_hit    = w_rd_entry.valid && (w_rd_entry.tag == w_rd_tag);
        o_rd_taken  = w_rd_hit && ((w_rd_entry.ctr == WT) || (w_rd_entry.ctr == ST));
        o_rd_target = w_rd_entry.target;
    end

    // EX training: train on hit, allocate on taken miss, invalidate alias.
    always_comb begin
        w_ex_entry = r_tbl[w_ex_idx];
        w_ex_hit   = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);
        w_we       = 1'b0;
        w_new      = w_ex_entry;
        if (i_wr_en) begin
            if (w_ex_hit) begin
                w_we      = 1'b1;
                w_new.ctr = ctr_train(w_ex_entry.ctr, i_wr_taken);
                if (i_wr_taken) w_new.target = i_wr_target;
            end else if (i_wr_taken) begin
                w_we         = 1'b1;
                w_new.valid  = 1'b1;
                w_new.tag    = w_ex_tag;
                w_new.target = i_wr_target;
                w_new.ctr    = i_wr_jump ? ST : WT;
            end
        end else if (i_inv_en) begin
            w_we        = 1'b1;
            w_new.valid = 1'b0;
        end
    end

    // Table storage; reset leaves every entry invalid and weakly not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
            end
        end else if (w_we) begin
            r_tbl[w_ex_idx] <= w_new;
        end
    end

endmodule
`default_nettype wire

// File: rtl/branch_predict_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predict_ctrl
//  Description : IF-stage branch prediction from a BTB, EX-stage mispredict
//                detection with zero-latency redirect/flush, table training
//                and saturating branch / mispredict statistics.
//  Revision    : 1.0  initial release
// ============================================================================
module branch_predict_ctrl
    import branch_predict_ctrl_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int CNT_W   = BP_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_predict_ctrl_if.slave bus
);

    logic             w_ctl;
    logic             w_taken;
    logic             w_alias;
    logic             w_mis;
    word_t            w_ex_pc4;
    logic             w_rd_taken;
    word_t            w_rd_target;
    logic             w_redirect;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    bp_btb_table #(
        .ENTRIES (ENTRIES),
        .IDX_W   (IDX_W)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .i_rd_pc     (bus.if_pc),
        .o_rd_taken  (w_rd_taken),
        .o_rd_target (w_rd_target),
        .i_ex_pc     (bus.ex_pc),
        .i_wr_en     (w_ctl && !bus.stall),
        .i_wr_taken  (w_taken),
        .i_wr_jump   (bus.ex_is_jump),
        .i_wr_target (bus.ex_target),
        .i_inv_en    (w_alias && !bus.stall)
    );

    // Resolve: a jump wins over a branch flag; an IF prediction on a
    // non-control instruction is a BTB alias and must be undone.
    always_comb begin
        w_ex_pc4 = bus.ex_pc + 32'd4;
        w_ctl    = bus.ex_valid && (bus.ex_is_branch || bus.ex_is_jump);
        w_taken  = bus.ex_is_jump || (bus.ex_is_branch && bus.ex_zero);
        w_alias  = bus.ex_valid && !bus.ex_is_branch && !bus.ex_is_jump
                   && bus.ex_pred_taken;
        w_mis    = (w_ctl && ((bus.ex_pred_taken != w_taken) ||
                              (w_taken && (bus.ex_pred_target != bus.ex_target))))
                   || w_alias;
        w_redirect = w_mis && !rst;
    end

    assign bus.pred_taken  = w_rd_taken;
    assign bus.pred_target = w_rd_taken ? w_rd_target : (bus.if_pc + 32'd4);
    assign bus.redirect    = w_redirect;
    assign bus.flush       = w_redirect;
    // Non-taken fall-through is also the value driven when not redirecting.
    assign bus.redirect_pc = (w_mis && w_taken) ? bus.ex_target : w_ex_pc4;
    assign bus.branch_cnt  = r_branch_cnt;
    assign bus.mispred_cnt = r_mispred_cnt;

    // Saturating statistics, frozen while the pipeline is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (!bus.stall) begin
            if (w_ctl && (r_branch_cnt != {CNT_W{1'b1}}))
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            if (w_mis && (r_mispred_cnt != {CNT_W{1'b1}}))
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire
